ranc_grid_west_dispatcher: RTL and testbench

//  Sits between the host input buffer and the west edge of a GRID_DIMENSION_X x GRID_DIMENSION_Y core grid.

---
 rtl/ranc_pkg.sv | 36 +++
 rtl/ranc_dispatch_fifo.sv | 61 ++++++
 rtl/ranc_grid_west_dispatcher.sv | 136 +++++++++++++
 tb/tb_ranc_grid_west_dispatcher.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ranc_pkg.sv
// Shared field layout, packet helpers and FSM states
// for the RANC grid west-edge dispatcher.
package ranc_pkg;

  localparam int PKT_W    = 30;
  localparam int DX_MSB   = 29;
  localparam int DX_LSB   = 21;
  localparam int DY_MSB   = 20;
  localparam int DY_LSB   = 12;
  localparam int DY_W     = DY_MSB - DY_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  typedef struct packed {
    logic [DY_W-1:0]  dy;
    logic [PKT_W-1:0] fwd;
  } split_t;

  // dy as seen by the router, plus the packet as
  // forwarded into the row with dy cleared
  function automatic split_t split_dy(
    input logic [PKT_W-1:0] p
  );
    split_t s;
    s.dy  = p[DY_MSB:DY_LSB];
    s.fwd = {p[DX_MSB:DX_LSB],
             {DY_W{1'b0}},
             p[DY_LSB-1:0]};
    return s;
  endfunction

endpackage

// File: rtl/ranc_dispatch_fifo.sv
// Per-row packet queue with a registered read port,
// matching the timing of the host input buffer.
module ranc_dispatch_fifo
  import ranc_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        data   <= mem[rd_ptr];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ranc_grid_west_dispatcher.sv
// Routes host packets to per-row west queues by dy
// and folds per-core status into grid-level flags.
module ranc_grid_west_dispatcher
  import ranc_pkg::*;
#(
  parameter int GRID_DIMENSION_X = 2,
  parameter int GRID_DIMENSION_Y = 2,
  parameter int PACKET_WIDTH     = 30,
  parameter int ROW_FIFO_DEPTH   = 4,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic input_buffer_empty,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  output logic ren_to_input_buffer,
  output logic [GRID_DIMENSION_Y*PACKET_WIDTH-1:0]
               west_in,
  output logic [GRID_DIMENSION_Y-1:0] empty_in_west,
  input  logic [GRID_DIMENSION_Y-1:0] ren_out_west,
  input  logic [GRID_DIMENSION_X*GRID_DIMENSION_Y-1:0]
               core_done,
  input  logic [GRID_DIMENSION_X*GRID_DIMENSION_Y-1:0]
               token_controller_error,
  input  logic [GRID_DIMENSION_X*GRID_DIMENSION_Y-1:0]
               scheduler_error,
  output logic cores_done,
  output logic token_controller_error_any,
  output logic scheduler_error_any,
  output logic route_error,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count
);

  localparam int Y  = GRID_DIMENSION_Y;
  localparam int RW = (Y > 1) ? $clog2(Y) : 1;

  state_t           state;
  state_t           next_state;
  logic [PKT_W-1:0] hold;
  split_t           dec;
  logic             row_ok;
  logic [RW-1:0]    row;
  logic [Y-1:0]     push;
  logic [Y-1:0]     full;
  logic             drop;

  assign dec    = split_dy(hold);
  assign row_ok = !dec.dy[DY_W-1] &&
                  (32'(dec.dy) < 32'(Y));
  assign row    = dec.dy[RW-1:0];
  assign drop   = (state == ST_DISPATCH) && !row_ok;

  always_comb begin
    next_state          = state;
    ren_to_input_buffer = 1'b0;
    push                = '0;
    unique case (state)
      ST_IDLE: begin
        if (!input_buffer_empty) begin
          ren_to_input_buffer = 1'b1;
          next_state          = ST_WAIT;
        end
      end
      ST_WAIT: next_state = ST_DISPATCH;
      ST_DISPATCH: begin
        if (!row_ok) begin
          next_state = ST_IDLE;
        end else if (!full[row]) begin
          push[row]  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_WAIT) begin
        hold <= packet_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      route_error   <= 1'b0;
      dropped_count <= '0;
    end else if (drop) begin
      route_error <= 1'b1;
      if (dropped_count != '1) begin
        dropped_count <= dropped_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cores_done                 <= 1'b0;
      token_controller_error_any <= 1'b0;
      scheduler_error_any        <= 1'b0;
    end else begin
      cores_done <= (&core_done) &&
                    (&empty_in_west) &&
                    (state == ST_IDLE) &&
                    input_buffer_empty;
      token_controller_error_any <=
        token_controller_error_any |
        (|token_controller_error);
      scheduler_error_any <=
        scheduler_error_any | (|scheduler_error);
    end
  end

  for (genvar r = 0; r < Y; r++) begin : g_row
    ranc_dispatch_fifo #(
      .WIDTH (PACKET_WIDTH),
      .DEPTH (ROW_FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[r]),
      .push_data (dec.fwd),
      .pop       (ren_out_west[r]),
      .data      (west_in[r*PACKET_WIDTH +:
                          PACKET_WIDTH]),
      .empty     (empty_in_west[r]),
      .full      (full[r])
    );
  end

endmodule

// File: tb/tb_ranc_grid_west_dispatcher.sv
// Scoreboard bench for the west dispatcher: host buffer
// model feeds packets, a monitor checks every row pop.
module tb_ranc_grid_west_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        input_buffer_empty = 1'b1;
  logic [29:0] packet_in = '0;
  logic        ren_to_input_buffer;
  logic [59:0] west_in;
  logic [1:0]  empty_in_west;
  logic [1:0]  ren_out_west = '0;
  logic [3:0]  core_done = '0;
  logic [3:0]  token_controller_error = '0;
  logic [3:0]  scheduler_error = '0;
  logic        cores_done;
  logic        token_controller_error_any;
  logic        scheduler_error_any;
  logic        route_error;
  logic [15:0] dropped_count;

  int n_chk = 0;
  int n_fail = 0;
  int ren_cnt = 0;
  int exp_reads = 0;
  int exp_drops = 0;

  logic [29:0] host_q [$];
  logic [29:0] exp_q0 [$];
  logic [29:0] exp_q1 [$];

  ranc_grid_west_dispatcher dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .input_buffer_empty         (input_buffer_empty),
    .packet_in                  (packet_in),
    .ren_to_input_buffer        (ren_to_input_buffer),
    .west_in                    (west_in),
    .empty_in_west              (empty_in_west),
    .ren_out_west               (ren_out_west),
    .core_done                  (core_done),
    .token_controller_error     (token_controller_error),
    .scheduler_error            (scheduler_error),
    .cores_done                 (cores_done),
    .token_controller_error_any (token_controller_error_any),
    .scheduler_error_any        (scheduler_error_any),
    .route_error                (route_error),
    .dropped_count              (dropped_count)
  );

  always #5 clk = ~clk;

  // host input buffer: registered read data
  always @(posedge clk) begin
    if (ren_to_input_buffer) begin
      ren_cnt++;
      if (host_q.size() > 0)
        packet_in <= host_q.pop_front();
    end
  end

  always @(negedge clk)
    input_buffer_empty = (host_q.size() == 0);

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [29:0] mk(
    input int dx, input int dy, input int low);
    logic [8:0]  x;
    logic [8:0]  y;
    logic [11:0] l;
    x = 9'(dx);
    y = 9'(dy);
    l = 12'(low);
    return {x, y, l};
  endfunction

  function automatic logic [29:0] fwd(
    input logic [29:0] p);
    return {p[29:21], 9'd0, p[11:0]};
  endfunction

  // row < 0 means the packet should be dropped
  task automatic send(input logic [29:0] p,
                      input int row);
    host_q.push_back(p);
    exp_reads++;
    if (row == 0) exp_q0.push_back(fwd(p));
    else if (row == 1) exp_q1.push_back(fwd(p));
    else exp_drops++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: a pop at an edge shows data by the
  // following negedge
  initial begin
    logic [1:0]  pf;
    logic [29:0] e;
    forever begin
      @(posedge clk);
      pf = ren_out_west & ~empty_in_west &
           {2{reset_n}};
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (pf[r]) begin
          if (r == 0 && exp_q0.size() > 0)
            e = exp_q0.pop_front();
          else if (r == 1 && exp_q1.size() > 0)
            e = exp_q1.pop_front();
          else
            e = 'x;
          if (r == 0)
            chk("row0_data", 64'(west_in[29:0]),
                64'(e));
          else
            chk("row1_data", 64'(west_in[59:30]),
                64'(e));
        end
      end
    end
  end

  initial begin
    bit seen;
    // reset state
    cyc(3);
    chk("rst_empty", 64'(empty_in_west), 64'h3);
    chk("rst_west", 64'(west_in), 64'h0);
    chk("rst_ren", 64'(ren_to_input_buffer), 64'h0);
    chk("rst_rerr", 64'(route_error), 64'h0);
    chk("rst_drop", 64'(dropped_count), 64'h0);
    chk("rst_done", 64'(cores_done), 64'h0);
    reset_n = 1'b1;
    cyc(2);

    // single packet to row1
    send(30'h0060_1120, 1);
    cyc(8);
    chk("t1_empty", 64'(empty_in_west), 64'h1);
    chk("t1_reads", 64'(ren_cnt), 64'(exp_reads));
    exp_q1.delete();
    exp_q1.push_back(30'h0060_0120);
    ren_out_west = 2'b10;
    cyc(1);
    ren_out_west = 2'b00;
    cyc(1);
    chk("t1_drained", 64'(empty_in_west), 64'h3);

    // out-of-range rows are dropped
    send(mk(3, 2, 'h120), -1);
    cyc(6);
    chk("t2_rerr", 64'(route_error), 64'h1);
    chk("t2_drop1", 64'(dropped_count), 64'h1);
    send(30'h007F_F120, -1);
    cyc(6);
    chk("t2_drop2", 64'(dropped_count),
        64'(exp_drops));
    chk("t2_nopush", 64'(empty_in_west), 64'h3);

    // back-pressure on a full row queue
    for (int i = 1; i <= 5; i++)
      send(mk(4, 0, i), 0);
    send(mk(5, 1, 6), 1);
    cyc(30);
    chk("t3_reads", 64'(ren_cnt), 64'(exp_reads - 1));
    chk("t3_held", 64'(input_buffer_empty), 64'h0);
    chk("t3_empty", 64'(empty_in_west), 64'h2);
    ren_out_west = 2'b01;
    cyc(1);
    ren_out_west = 2'b00;
    cyc(12);
    chk("t3_resume", 64'(ren_cnt), 64'(exp_reads));
    chk("t3_row1", 64'(empty_in_west[1]), 64'h0);
    for (int i = 0; i < 8; i++) begin
      ren_out_west = ~empty_in_west;
      cyc(1);
    end
    ren_out_west = 2'b00;
    cyc(1);
    chk("t3_drained", 64'(empty_in_west), 64'h3);

    // interleaved rows with continuous pops
    ren_out_west = 2'b11;
    send(mk(1, 0, 'h7), 0);
    send(mk(2, 1, 'h8), 1);
    send(mk(9, 0, 'h9), 0);
    cyc(20);
    ren_out_west = 2'b00;
    cyc(1);
    chk("t4_empty", 64'(empty_in_west), 64'h3);
    chk("t4_reads", 64'(ren_cnt), 64'(exp_reads));

    // cores_done and sticky error flags
    core_done = 4'hF;
    send(mk(6, 0, 'hA), 0);
    cyc(8);
    chk("t5_busy", 64'(cores_done), 64'h0);
    ren_out_west = 2'b01;
    cyc(1);
    ren_out_west = 2'b00;
    chk("t5_popedge", 64'(cores_done), 64'h0);
    cyc(1);
    chk("t5_done", 64'(cores_done), 64'h1);
    token_controller_error = 4'b0100;
    cyc(1);
    token_controller_error = 4'b0000;
    cyc(2);
    chk("t5_tce", 64'(token_controller_error_any),
        64'h1);
    chk("t5_sch0", 64'(scheduler_error_any), 64'h0);
    scheduler_error = 4'b0001;
    cyc(1);
    scheduler_error = 4'b0000;
    cyc(2);
    chk("t5_sch1", 64'(scheduler_error_any), 64'h1);
    chk("t5_tce_sticky",
        64'(token_controller_error_any), 64'h1);
    core_done = 4'h0;

    // reset while a read is in flight
    send(mk(1, 0, 'h21), 0);
    send(mk(1, 0, 'h22), 0);
    send(mk(1, 1, 'h23), 1);
    send(mk(1, 1, 'h24), 1);
    cyc(20);
    chk("t6_half", 64'(empty_in_west), 64'h0);
    send(mk(7, 0, 'h25), 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      if (ren_to_input_buffer) seen = 1'b1;
    end
    chk("t6_read_seen", 64'(seen), 64'h1);
    #1 reset_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_drops = 0;
    cyc(2);
    chk("t6_rst_empty", 64'(empty_in_west), 64'h3);
    chk("t6_rst_drop", 64'(dropped_count), 64'h0);
    chk("t6_rst_rerr", 64'(route_error), 64'h0);
    chk("t6_rst_tce",
        64'(token_controller_error_any), 64'h0);
    reset_n = 1'b1;
    cyc(12);
    chk("t6_no_stale", 64'(empty_in_west), 64'h3);
    chk("t6_west", 64'(west_in), 64'h0);
    chk("t6_reads", 64'(ren_cnt), 64'(exp_reads));

    chk("sb_q0_left", 64'(exp_q0.size()), 64'h0);
    chk("sb_q1_left", 64'(exp_q1.size()), 64'h0);
    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
